// File: rtl/serial_shift_out_pkg.sv
// Shared types and helpers for the serial shift-out stage of the Wishbone serial port.
package serial_shift_out_pkg;

  localparam int SER_WIDTH_DEF  = 8;
  localparam int SER_CLKDIV_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_shift_out_tick.sv
// Enable-gated divider: one-cycle tick every CLKDIV enabled cycles, sync clear to zero.
module serial_tick_gen
  import serial_shift_out_pkg::*;
#(
  parameter int CLKDIV = SER_CLKDIV_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CNT_W = clog2_min1(CLKDIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKDIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = '0;
        tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_shift_out.sv
// Parallel-to-serial driver for 74HC595-style chains: sclk/sdat/latch with a one-word
// holding register so the next frame can follow after a single LOAD cycle.
module serial_shift_out
  import serial_shift_out_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter int CLKDIV    = SER_CLKDIV_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic [WIDTH-1:0] dat_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             sclk_o,
  output logic             sdat_o,
  output logic             latch_o
);

  localparam int BIT_W = clog2_min1(WIDTH);

  state_e           state_q, state_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] hold_dat_q, hold_dat_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             sclk_q, sclk_d;
  logic             sdat_q, sdat_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             accept;
  logic             tick;
  logic             div_en;
  logic             div_clr;

  function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w << 1;
    else                return w >> 1;
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  assign accept  = valid_i & ready_q;
  assign div_en  = (state_q == ST_SHIFT) | (state_q == ST_LATCH);
  assign div_clr = ~div_en;

  serial_tick_gen #(
    .CLKDIV (CLKDIV)
  ) u_tick (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_dat_d  = hold_dat_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    sclk_d      = sclk_q;
    sdat_d      = sdat_q;
    latch_d     = latch_q;

    // ready_q is low whenever the holding register is full, so accept never meets a pull.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_dat_d  = dat_i;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shreg_d     = hold_dat_q;
        hold_full_d = 1'b0;
        sdat_d      = head_bit(hold_dat_q);
        bit_cnt_d   = BIT_W'(WIDTH - 1);
        sclk_d      = 1'b0;
        state_d     = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Data only moves on the falling edge so the chain sees it stable at the rise.
            sclk_d = 1'b0;
            if (bit_cnt_q != '0) begin
              shreg_d   = shift_word(shreg_q);
              sdat_d    = head_bit(shift_word(shreg_q));
              bit_cnt_d = bit_cnt_q - 1'b1;
            end else begin
              latch_d = 1'b1;
              state_d = ST_LATCH;
            end
          end
        end
      end
      ST_LATCH: begin
        if (tick) begin
          latch_d = 1'b0;
          state_d = hold_full_q ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE) | hold_full_d;
    ready_d = ~hold_full_d;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      sdat_q      <= 1'b0;
      latch_q     <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      sclk_q      <= sclk_d;
      sdat_q      <= sdat_d;
      latch_q     <= latch_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
    end
  end

  // Payload registers are qualified by hold_full/state, so they carry no reset.
  always_ff @(posedge wb_clk_i) begin
    hold_dat_q <= hold_dat_d;
    shreg_q    <= shreg_d;
  end

  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign sclk_o  = sclk_q;
  assign sdat_o  = sdat_q;
  assign latch_o = latch_q;

endmodule

// File: tb/tb_serial_shift_out.sv
// Randomised bench: two serial_shift_out instances (MSB-first CLKDIV=2, LSB-first CLKDIV=1)
// decoded from their serial pins and compared against the words the bench handed over.
module tb_serial_shift_out;

  localparam int W   = 8;
  localparam int CDA = 2;
  localparam int CDB = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] dat_v [2];
  logic [1:0]   vld_v;
  logic [1:0]   rdy_v, busy_v, sclk_v, sdat_v, latch_v;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] expq0[$];
  logic [W-1:0] expq1[$];

  int           cyc = 0;
  int           nbits      [2];
  int           first_rise [2];
  int           last_fall  [2];
  int           gap        [2];
  int           lat_len    [2];
  int           n_latch    [2];
  logic [W-1:0] rx         [2];
  logic         prev_sclk  [2];
  logic         prev_sdat  [2];
  logic         prev_latch [2];

  always #5 clk = ~clk;

  serial_shift_out #(.WIDTH(W), .CLKDIV(CDA), .MSB_FIRST(1)) dut_a (
    .wb_clk_i (clk),       .wb_rst_ni (rst_n),
    .dat_i    (dat_v[0]),  .valid_i   (vld_v[0]),
    .ready_o  (rdy_v[0]),  .busy_o    (busy_v[0]),
    .sclk_o   (sclk_v[0]), .sdat_o    (sdat_v[0]),
    .latch_o  (latch_v[0])
  );

  serial_shift_out #(.WIDTH(W), .CLKDIV(CDB), .MSB_FIRST(0)) dut_b (
    .wb_clk_i (clk),       .wb_rst_ni (rst_n),
    .dat_i    (dat_v[1]),  .valid_i   (vld_v[1]),
    .ready_o  (rdy_v[1]),  .busy_o    (busy_v[1]),
    .sclk_o   (sclk_v[1]), .sdat_o    (sdat_v[1]),
    .latch_o  (latch_v[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cd_of(input int d);
    return (d == 0) ? CDA : CDB;
  endfunction

  // Monitor: rebuild each frame from the pins and grade it against the expected-word queue.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        nbits[d] = 0; lat_len[d] = 0; last_fall[d] = -1; first_rise[d] = 0;
        prev_sclk[d] = 1'b0; prev_sdat[d] = 1'b0; prev_latch[d] = 1'b0;
      end else begin
        if (sclk_v[d] && !prev_sclk[d]) begin
          if (nbits[d] == 0) begin
            first_rise[d] = cyc;
            if (last_fall[d] >= 0) gap[d] = cyc - last_fall[d];
          end
          if (nbits[d] < W) rx[d][(d == 0) ? (W - 1 - nbits[d]) : nbits[d]] = sdat_v[d];
          nbits[d]++;
        end
        if (sclk_v[d] && prev_sclk[d]) check_eq("sdat_stable_high", sdat_v[d], prev_sdat[d]);
        if (latch_v[d] && !prev_latch[d]) begin
          check_eq("bits_per_frame", nbits[d], W);
          check_eq("latch_start", cyc - first_rise[d], 2 * cd_of(d) * W - cd_of(d));
          if (d == 0) begin
            if (expq0.size() == 0) check_eq("unexpected_frame_a", 1, 0);
            else check_eq("word_a", rx[0], expq0.pop_front());
          end else begin
            if (expq1.size() == 0) check_eq("unexpected_frame_b", 1, 0);
            else check_eq("word_b", rx[1], expq1.pop_front());
          end
          lat_len[d] = 0;
        end
        if (latch_v[d]) lat_len[d]++;
        if (!latch_v[d] && prev_latch[d]) begin
          check_eq("latch_len", lat_len[d], cd_of(d));
          check_eq("frame_len", cyc - first_rise[d], 2 * cd_of(d) * W);
          last_fall[d] = cyc;
          nbits[d]     = 0;
          n_latch[d]++;
        end
        prev_sclk[d]  = sclk_v[d];
        prev_sdat[d]  = sdat_v[d];
        prev_latch[d] = latch_v[d];
      end
    end
    if (!rst_n) begin
      expq0.delete();
      expq1.delete();
    end
  end

  task automatic send(input int d, input logic [W-1:0] w);
    int n = 0;
    dat_v[d] = w;
    vld_v[d] = 1'b1;
    while (!rdy_v[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_v[d]) begin
      check_eq("send_timeout", 0, 1);
      vld_v[d] = 1'b0;
      return;
    end
    if (d == 0) expq0.push_back(w);
    else        expq1.push_back(w);
    @(negedge clk);
    vld_v[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    while (busy_v[d] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", busy_v[d], 0);
    @(negedge clk);
  endtask

  initial begin
    logic act;
    int   nl0;
    for (int d = 0; d < 2; d++) begin
      n_latch[d] = 0; gap[d] = 0; rx[d] = '0; dat_v[d] = '0;
    end
    vld_v = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_sclk", sclk_v[d], 0);
      check_eq("rst_sdat", sdat_v[d], 0);
      check_eq("rst_latch", latch_v[d], 0);
      check_eq("rst_busy", busy_v[d], 0);
      check_eq("rst_ready", rdy_v[d], 1);
    end
    rst_n = 1'b1;
    act = 1'b0;
    repeat (100) begin
      @(negedge clk);
      act = act | (|sclk_v) | (|sdat_v) | (|latch_v) | (|busy_v) | ~(&rdy_v);
    end
    check_eq("idle_quiet", act, 0);

    // Single 0xA5 frame, MSB first.
    send(0, 8'hA5);
    check_eq("ready_low_after_accept", rdy_v[0], 0);
    wait_idle(0);
    check_eq("ready_after_frame", rdy_v[0], 1);
    check_eq("latch_after_frame", latch_v[0], 0);

    // Back-to-back: second word queued during the first frame.
    send(0, 8'h3C);
    send(0, 8'hC3);
    check_eq("b2b_ready_low", rdy_v[0], 0);
    wait_idle(0);
    check_eq("b2b_gap", gap[0], 1 + CDA);

    // Three words offered continuously.
    nl0 = n_latch[0];
    send(0, 8'h11);
    send(0, 8'h22);
    check_eq("three_ready_low2", rdy_v[0], 0);
    send(0, 8'h33);
    check_eq("three_ready_low3", rdy_v[0], 0);
    wait_idle(0);
    check_eq("three_frames", n_latch[0] - nl0, 3);

    // Reset after three bits of 0x5A: outputs clear at once, no latch pulse.
    nl0 = n_latch[0];
    send(0, 8'h5A);
    begin
      int n = 0;
      while (nbits[0] < 3 && n < 500) begin
        @(negedge clk);
        n++;
      end
      check_eq("reach_3_bits", (nbits[0] >= 3), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_sclk", sclk_v[0], 0);
    check_eq("arst_sdat", sdat_v[0], 0);
    check_eq("arst_latch", latch_v[0], 0);
    check_eq("arst_busy", busy_v[0], 0);
    check_eq("arst_ready", rdy_v[0], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check_eq("no_latch_after_abort", n_latch[0] - nl0, 0);
    send(0, 8'hFF);
    wait_idle(0);
    check_eq("clean_frame_after_rst", n_latch[0] - nl0, 1);

    // LSB first, CLKDIV=1.
    send(1, 8'h01);
    wait_idle(1);
    check_eq("lsb_frame_count", n_latch[1], 1);

    // Random words with random spacing on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 3 * W * cd_of(d))) @(negedge clk);
        send(d, W'($urandom));
      end
      wait_idle(d);
    end

    check_eq("queue_a_drained", expq0.size(), 0);
    check_eq("queue_b_drained", expq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
